// File: rtl/laser_paced_tx.sv
// ============================================================================
// Module   : laser_paced_tx
// Brief    : Dual-lane paced laser transmitter. It serialises byte pairs as start/8-data/stop frames.
//            Optional macro LASER_TX_PARITY_EN adds an even-parity bit per lane.
// Revision : 1.0
// ============================================================================
`default_nettype none

module laser_paced_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int GAP_BITS     = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data1,
    input  logic [7:0] in_data2,
    input  logic       en,
    output logic [1:0] laser1_out,
    output logic [1:0] laser2_out,
    output logic       busy,
    output logic       done
);

    localparam int            c_TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_TW-1:0] c_TMAX   = c_TW'(CLKS_PER_BIT - 1);
    localparam logic [c_TW-1:0] c_TDONE  = c_TW'(CLKS_PER_BIT - 2);
    localparam logic [3:0]    c_GAP_LAST = 4'(GAP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    state_t          r_state;
    logic [c_TW-1:0] r_timer;
    logic [2:0]      r_idx;
    logic [3:0]      r_gap;
    logic [7:0]      r_sh1;
    logic [7:0]      r_sh2;
    logic [7:0]      r_buf1;
    logic [7:0]      r_buf2;
    logic            r_full;
    logic            r_live;
    logic            r_bit1;
    logic            r_bit2;
    logic            r_done;
`ifdef LASER_TX_PARITY_EN
    logic            r_par1;
    logic            r_par2;
`endif

    logic w_tick;
    logic w_accept;

    assign w_tick   = (r_timer == c_TMAX);
    // r_live keeps in_ready low until the first edge after reset releases
    assign in_ready = r_live & ~r_full;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_idx   <= '0;
            r_gap   <= '0;
            r_sh1   <= '0;
            r_sh2   <= '0;
            r_buf1  <= '0;
            r_buf2  <= '0;
            r_full  <= 1'b0;
            r_live  <= 1'b0;
            r_bit1  <= 1'b0;
            r_bit2  <= 1'b0;
            r_done  <= 1'b0;
`ifdef LASER_TX_PARITY_EN
            r_par1  <= 1'b0;
            r_par2  <= 1'b0;
`endif
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;

            if (w_accept) begin
                r_full <= 1'b1;
                r_buf1 <= in_data1;
                r_buf2 <= in_data2;
            end

            if (r_state == S_IDLE || w_tick) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_full) begin
                        r_full  <= 1'b0;
                        r_sh1   <= r_buf1;
                        r_sh2   <= r_buf2;
`ifdef LASER_TX_PARITY_EN
                        r_par1  <= ^r_buf1;
                        r_par2  <= ^r_buf2;
`endif
                        r_bit1  <= 1'b1;
                        r_bit2  <= 1'b1;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_idx   <= '0;
                        r_bit1  <= r_sh1[0];
                        r_bit2  <= r_sh2[0];
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_sh1 <= r_sh1 >> 1;
                        r_sh2 <= r_sh2 >> 1;
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
`ifdef LASER_TX_PARITY_EN
                            r_bit1  <= r_par1;
                            r_bit2  <= r_par2;
                            r_state <= S_PARITY;
`else
                            r_bit1  <= 1'b0;
                            r_bit2  <= 1'b0;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit1 <= r_sh1[1];
                            r_bit2 <= r_sh2[1];
                        end
                    end
                end
`ifdef LASER_TX_PARITY_EN
                S_PARITY: begin
                    if (w_tick) begin
                        r_bit1  <= 1'b0;
                        r_bit2  <= 1'b0;
                        r_state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    // Registered, so it is raised one clock early to land on the last STOP clock
                    if (r_timer == c_TDONE) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        r_gap   <= '0;
                        r_state <= (GAP_BITS == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        if (r_gap == c_GAP_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_gap <= r_gap + 4'd1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign laser1_out = {r_bit1 & en, en};
    assign laser2_out = {r_bit2 & en, en};
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_laser_paced_tx.sv
// Testbench for laser_paced_tx: two instances (different pacing) are checked every clock against a frame-level model.
`default_nettype none

module tb_laser_paced_tx;

    localparam int C0 = 8;
    localparam int G0 = 1;
    localparam int C1 = 3;
    localparam int G1 = 0;
`ifdef LASER_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        int         kk;
        int         acc;
        logic [7:0] a;
        logic [7:0] b;
    } frame_t;

    logic        clock;
    logic        reset;
    logic        en;
    logic [1:0]  vld;
    logic [1:0]  rdy;
    logic [1:0]  bsy;
    logic [1:0]  dn;
    logic [15:0] da;
    logic [15:0] db;
    logic [3:0]  l1;
    logic [3:0]  l2;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    frame_t q[$];

    laser_paced_tx #(.CLKS_PER_BIT(C0), .GAP_BITS(G0)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(vld[0]), .in_ready(rdy[0]),
        .in_data1(da[7:0]), .in_data2(db[7:0]), .en(en),
        .laser1_out(l1[1:0]), .laser2_out(l2[1:0]), .busy(bsy[0]), .done(dn[0])
    );

    laser_paced_tx #(.CLKS_PER_BIT(C1), .GAP_BITS(G1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(vld[1]), .in_ready(rdy[1]),
        .in_data1(da[15:8]), .in_data2(db[15:8]), .en(en),
        .laser1_out(l1[3:2]), .laser2_out(l2[3:2]), .busy(bsy[1]), .done(dn[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, act, exp);
        end
    endtask

    // Line level of frame bit n: start=1, data LSB first, optional parity, stop=0
    function automatic logic fbit(input logic [7:0] d, input int n);
        if (n == 0) return 1'b1;
        if (n <= 8) return d[n-1];
`ifdef LASER_TX_PARITY_EN
        if (n == 9) return ^d;
`endif
        return 1'b0;
    endfunction

    function automatic bit pending(input int k, input int t);
        foreach (q[i]) if (q[i].kk == k && q[i].acc <= t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic monitor(input int k);
        int C = (k == 0) ? C0 : C1;
        int G = (k == 0) ? G0 : G1;
        int total = NB * C + G * C;
        int start = 0;
        int next_free = 0;
        int off;
        int idx;
        int exp_start;
        bit in_frame = 1'b0;
        bit rel = 1'b0;
        logic [7:0] a = '0;
        logic [7:0] b = '0;
        logic e1, e2, eb, ed;
        forever begin
            @(negedge clock);
            if (reset) begin
                in_frame  = 1'b0;
                next_free = 0;
                rel       = 1'b0;
                chk(k, "rst_l1", 32'(l1[k*2 +: 2]), {30'd0, 1'b0, en});
                chk(k, "rst_l2", 32'(l2[k*2 +: 2]), {30'd0, 1'b0, en});
                chk(k, "rst_busy", 32'(bsy[k]), 0);
                chk(k, "rst_done", 32'(dn[k]), 0);
                chk(k, "rst_ready", 32'(rdy[k]), 0);
            end else begin
                if (in_frame && (cyc - start) >= total) in_frame = 1'b0;
                if (!in_frame && bsy[k]) begin
                    idx = -1;
                    foreach (q[i]) if (idx < 0 && q[i].kk == k) idx = i;
                    if (idx < 0) begin
                        chk(k, "unexpected_frame", 1, 0);
                    end else begin
                        exp_start = (q[idx].acc + 1 > next_free) ? q[idx].acc + 1 : next_free;
                        chk(k, "start_cyc", cyc, exp_start);
                        a = q[idx].a;
                        b = q[idx].b;
                        q.delete(idx);
                        in_frame  = 1'b1;
                        start     = cyc;
                        next_free = cyc + total + 1;
                    end
                end
                e1 = 1'b0; e2 = 1'b0; eb = 1'b0; ed = 1'b0;
                if (in_frame) begin
                    off = cyc - start;
                    eb  = 1'b1;
                    if (off < NB * C) begin
                        e1 = fbit(a, off / C);
                        e2 = fbit(b, off / C);
                        ed = (off == NB * C - 1);
                    end
                end
                chk(k, "lane1", 32'(l1[k*2 +: 2]), {30'd0, e1 & en, en});
                chk(k, "lane2", 32'(l2[k*2 +: 2]), {30'd0, e2 & en, en});
                chk(k, "busy", 32'(bsy[k]), 32'(eb));
                chk(k, "done", 32'(dn[k]), 32'(ed));
                chk(k, "ready", 32'(rdy[k]), rel ? 32'(!pending(k, cyc)) : 0);
                rel = 1'b1;
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called and returns at posedge+1; the transfer happens on the edge in between
    task automatic send(input int k, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        frame_t f;
        vld[k] = 1'b1;
        da[k*8 +: 8] = a;
        db[k*8 +: 8] = b;
        while (!rdy[k] && n < 1000) begin
            tick(1);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout dut%0d got=ready_low exp=ready_high", k);
            vld[k] = 1'b0;
        end else begin
            f.kk = k; f.acc = cyc + 1; f.a = a; f.b = b;
            q.push_back(f);
            tick(1);
            vld[k] = 1'b0;
            da[k*8 +: 8] = 8'($urandom);
            db[k*8 +: 8] = 8'($urandom);
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        tick(1);
        while (!(rdy[k] && !bsy[k]) && n < 3000) begin
            tick(1);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout dut%0d got=busy exp=idle", k);
        end
    endtask

    initial begin
        int t0;
        int n;
        reset = 1'b1;
        en    = 1'b1;
        vld   = '0;
        da    = '0;
        db    = '0;
        fork
            monitor(0);
            monitor(1);
        join_none
        tick(3);
        reset = 1'b0;
        tick(50);

        send(0, 8'hA5, 8'h3C);
        wait_idle(0);

        send(1, 8'h01, 8'h02);
        send(1, 8'h03, 8'h04);
        send(1, 8'h05, 8'h06);
        wait_idle(1);

        en = 1'b0;
        send(0, 8'hFF, 8'hFF);
        wait_idle(0);
        en = 1'b1;
        send(0, 8'h5A, 8'hC3);
        send(0, 8'h07, 8'h03);
        wait_idle(0);

        for (int i = 0; i < 24; i++) begin
            en = ($urandom_range(0, 3) != 0);
            send(int'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            tick(int'($urandom_range(0, 20)));
        end
        en = 1'b1;
        wait_idle(0);
        wait_idle(1);

        // Reset on clock 35 of a frame while the next pair sits in the buffer
        send(0, 8'h96, 8'h69);
        n = 0;
        while (!bsy[0] && n < 100) begin
            tick(1);
            n++;
        end
        t0 = cyc;
        send(0, 8'hE1, 8'h1E);
        while (cyc < t0 + 34) tick(1);
        reset = 1'b1;
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].kk == 0) q.delete(i);
        tick(2);
        reset = 1'b0;
        tick(30);
        send(0, 8'h07, 8'h03);
        wait_idle(0);
        wait_idle(1);
        tick(5);

        chk(0, "leftover_pairs", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/laser_paced_tx.md
Name: laser_paced_tx

Overview:
Dual-lane paced laser transmitter. It takes byte pairs through a valid/ready handshake and serialises each byte onto its own laser lane as one UART-style frame: start, 8 data bits, stop. Every bit is held for CLKS_PER_BIT clocks, matching the oversampling receiver's 8-clock bit period. It sits between the host-side byte FIFO and the laser driver pins, with a one-entry holding buffer so upstream can pre-load the next pair while a frame is on the wire.

Parameters:
CLKS_PER_BIT, 8, clocks per transmitted bit; legal values are 2 to 255.
GAP_BITS, 1, idle bit-times forced low between consecutive frames; legal values are 0 to 15.

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high
in_valid  input  1  upstream has a byte pair on in_data1/in_data2
in_ready  output  1  holding buffer empty; a transfer occurs when in_valid && in_ready at a clock edge
in_data1  input  8  byte for lane 1
in_data2  input  8  byte for lane 2
en  input  1  laser driver enable
laser1_out  output  2  {lane-1 bit & en, en}
laser2_out  output  2  {lane-2 bit & en, en}
busy  output  1  high while in START, DATA, STOP or GAP
done  output  1  one-cycle pulse in the final clock of each STOP bit

Behaviour:
- Reset is asynchronous, active-high; clock is clock.
- Reset values:
  - state = IDLE; holding buffer empty.
  - Lane bit registers = 0.
  - busy = 0; done = 0.
  - in_ready = 0 while reset is asserted, 1 from the first edge after release.
  - laser*_out = {0, en}.
- Frame per lane: idle low; start bit = 1; data bits LSB first (d[0]..d[7]); stop bit = 0. Both lanes are always bit-aligned.
- Holding buffer:
  - Loads on in_valid && in_ready. in_ready = !buf_full (registered flag).
  - Accepted even mid-frame. Emptied when the FSM launches a frame.
  - Simultaneous accept and launch in one cycle is impossible, because launch needs buf_full = 1, which forces in_ready = 0.
- Counters:
  - bit-timer: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1, then wraps to 0 and generates bit_tick.
  - bit index: 3 bits, for the data bits.
  - gap counter: 4 bits.
- FSM states:
  - IDLE: if buf_full, move the buffer into the lane shift registers, clear the timer, go to START. Otherwise stay.
  - START: lane bits = 1. On bit_tick go to DATA with index 0.
  - DATA: lane bit = shreg[0]. On bit_tick, shift right and increment the index; when index == 7, go to STOP.
  - STOP: lane bits = 0. done = 1 when the timer == CLKS_PER_BIT-1. On bit_tick go to GAP, or go to IDLE if GAP_BITS == 0.
  - GAP: lane bits = 0. After GAP_BITS bit_ticks go to IDLE.
- Latency:
  - A pair accepted at edge T0 while IDLE: lane outputs go high after edge T0+1.
  - Frame length is 10*CLKS_PER_BIT clocks, plus GAP_BITS*CLKS_PER_BIT of gap.
  - Back-to-back frames with GAP_BITS=0: the next start bit follows the stop bit after exactly 1 idle clock (the IDLE launch cycle).
- Lane bits are registered. laser*_out is combinational from the lane bit register and en.
- en = 0 only masks the output bit. Frame timing, handshake and done proceed unchanged.
- in_valid dropping after a transfer has no effect. in_data is sampled only at the transfer edge.
- Reset mid-frame: outputs return to their reset values immediately and the buffered pair is discarded. No done pulse.

Optional Feature:
LASER_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. Each lane sends the even-parity bit of its own byte (XOR of its 8 bits) for one bit-time. Frame length becomes 11*CLKS_PER_BIT. done timing is still the last clock of STOP.
- Undefined: no PARITY state; frame is 10 bits; no parity logic is synthesised.

Test Plan:
- Reset, then hold in_valid=0 for 50 clocks -> laser1_out=laser2_out=2'b01 (en=1), busy=0, done=0, in_ready=1 throughout.
- CLKS_PER_BIT=8, send pair 8'hA5/8'h3C once, sample each bit mid-period -> lane1 bits 1,1,0,1,0,0,1,0,1,0; lane2 bits 1,0,0,1,1,1,1,0,0,0; one done pulse at clock 80 after start; busy drops afterwards.
- GAP_BITS=0, in_valid held high with three pairs 01/02, 03/04, 05/06 -> three contiguous frames, each start bit 1 clock after the prior stop bit ends; in_ready low while the buffer holds a pair; exactly 3 done pulses.
- en=0 during a full 8'hFF/8'hFF frame -> laser*_out stays 2'b00; done still pulses after 80 clocks; the next frame with en=1 transmits correctly.
- Assert reset at clock 35 of a frame, with the next pair already buffered -> outputs go to reset values in the same cycle; after release there is no transmission until a new pair is accepted.
- With LASER_TX_PARITY_EN defined, send 8'h07/8'h03 -> parity bits lane1=1, lane2=0 at bit 9; stop at bit 10; done at clock 88.
